// File: rtl/decode_pkg.sv
// Shared definitions for the decode/sequencing front-end: opcodes, field
// positions, sequencer states and the multi-word beat count helper.
package decode_pkg;

  localparam logic [5:0] OPC_NOP = 6'h00;
  localparam logic [5:0] OPC_LDM = 6'h20;
  localparam logic [5:0] OPC_STM = 6'h28;

  localparam int OP_LSB  = 26;
  localparam int RD_LSB  = 22;
  localparam int RS_LSB  = 18;
  localparam int RT_LSB  = 14;
  localparam int IMM_LSB = 0;

  typedef enum logic {
    IDLE = 1'b0,
    SEQ  = 1'b1
  } seq_state_e;

  // Beats of an LDM/STM: rt+1, clamped to the configured maximum.
  function automatic int word_count(input int rt, input int max_words);
    int w;
    w = rt + 32'sd1;
    if (w > max_words) begin
      w = max_words;
    end else begin
      w = rt + 32'sd1;
    end
    return w;
  endfunction

endpackage

// File: rtl/decode_seq_unit_if.sv
// Fetch/control/datapath-side signal bundle of decode_seq_unit.
interface decode_seq_unit_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4,
  parameter int OPC_W  = 6,
  parameter int BEAT_W = 2
);
  logic [DATA_W-1:0] inst_in;
  logic [DATA_W-1:0] pc_in;
  logic              stall;
  logic              flush;
  logic              imm_ext;
  logic              call;
  logic              reg_dst;
  logic [DATA_W-1:0] rs_val;

  logic [OPC_W-1:0]  op_code;
  logic [REG_AW-1:0] rs;
  logic [REG_AW-1:0] rt;
  logic [REG_AW-1:0] rb;
  logic [REG_AW-1:0] rd_buf;
  logic [DATA_W-1:0] imm_out;
  logic [DATA_W-1:0] target;
  logic              eqz;
  logic              ltz;
  logic [BEAT_W-1:0] beat_idx;
  logic              last_beat;
  logic              hold_fetch;
  logic              uop_valid;
  logic              illegal_op;

  modport master (
    output inst_in, pc_in, stall, flush, imm_ext, call, reg_dst, rs_val,
    input  op_code, rs, rt, rb, rd_buf, imm_out, target, eqz, ltz,
           beat_idx, last_beat, hold_fetch, uop_valid, illegal_op
  );

  modport slave (
    input  inst_in, pc_in, stall, flush, imm_ext, call, reg_dst, rs_val,
    output op_code, rs, rt, rb, rd_buf, imm_out, target, eqz, ltz,
           beat_idx, last_beat, hold_fetch, uop_valid, illegal_op
  );
endinterface

// File: rtl/beat_seq.sv
// Multi-word sequencer: IDLE/SEQ FSM, beat counter, fetch hold and the
// instruction-register load enable.
module beat_seq
  import decode_pkg::*;
#(
  parameter int BEAT_W = 2
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              stall,
  input  logic              flush,
  input  logic              multi,
  input  logic [BEAT_W-1:0] beat_last,
  output logic [BEAT_W-1:0] beat,
  output logic              last_beat,
  output logic              hold_fetch,
  output logic              ld_en
);

  seq_state_e        state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;

  // Next state, beat and handshake outputs.
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    last_beat  = 1'b1;
    hold_fetch = 1'b0;
    ld_en      = 1'b0;
    case (state_q)
      IDLE: begin
        if (multi) begin
          last_beat  = 1'b0;
          hold_fetch = 1'b1;
          if (flush) begin
            ld_en = 1'b1;
          end else if (!stall) begin
            state_d = SEQ;
            beat_d  = BEAT_W'(1);
          end else begin
            state_d = state_q;
          end
        end else begin
          ld_en = flush | ~stall;
        end
      end
      SEQ: begin
        last_beat  = (beat_q == beat_last);
        hold_fetch = ~last_beat;
        if (flush || (!stall && last_beat)) begin
          ld_en   = 1'b1;
          state_d = IDLE;
          beat_d  = {BEAT_W{1'b0}};
        end else if (!stall) begin
          beat_d = beat_q + BEAT_W'(1);
        end else begin
          beat_d = beat_q;
        end
      end
      default: begin
        state_d = IDLE;
        beat_d  = {BEAT_W{1'b0}};
      end
    endcase
  end

  // State and beat registers.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= IDLE;
      beat_q  <= {BEAT_W{1'b0}};
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  assign beat = beat_q;

endmodule

// File: rtl/decode_seq_unit.sv
// Decode front-end with internal LDM/STM beat sequencing.
// Optional misaligned-rd fault: define DECODE_RD_ALIGN_CHECK_EN.
module decode_seq_unit
  import decode_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int REG_AW    = 4,
  parameter int IMM_W     = 14,
  parameter int OPC_W     = 6,
  parameter int MAX_WORDS = 4,
  parameter int CALL_REG  = 14
) (
  input logic               clk,
  input logic               clear,
  decode_seq_unit_if.slave  bus
);

  localparam int BEAT_W = $clog2(MAX_WORDS);

  logic [DATA_W-1:0] inst_q, inst_d, pc_q, pc_d;
  logic              valid_q, valid_d;
  logic [OPC_W-1:0]  op;
  logic [REG_AW-1:0] rd, rs, rt, rd_nb;
  logic [IMM_W-1:0]  imm, imm_sum;
  logic [BEAT_W-1:0] beat, beat_last;
  logic              multi_raw, misalign, multi, ld_en, last_beat, hold_fetch;
  int                words;

  assign op  = inst_q[OP_LSB +: OPC_W];
  assign rd  = inst_q[RD_LSB +: REG_AW];
  assign rs  = inst_q[RS_LSB +: REG_AW];
  assign rt  = inst_q[RT_LSB +: REG_AW];
  assign imm = inst_q[IMM_LSB +: IMM_W];

  // Beat count of the held instruction and its legality.
  always_comb begin
    words = 1;
    if ((op == OPC_W'(OPC_LDM)) || (op == OPC_W'(OPC_STM))) begin
      words = word_count(int'(rt), MAX_WORDS);
    end else begin
      words = 1;
    end
    multi_raw = (words > 1);
    beat_last = BEAT_W'(words - 1);
`ifdef DECODE_RD_ALIGN_CHECK_EN
    misalign = multi_raw && ((int'(rd) + words - 1) > ((2 ** REG_AW) - 1));
`else
    misalign = 1'b0;
`endif
    multi = multi_raw & ~misalign;
  end

  beat_seq #(.BEAT_W(BEAT_W)) u_beat_seq (
    .clk        (clk),
    .clear      (clear),
    .stall      (bus.stall),
    .flush      (bus.flush),
    .multi      (multi),
    .beat_last  (beat_last),
    .beat       (beat),
    .last_beat  (last_beat),
    .hold_fetch (hold_fetch),
    .ld_en      (ld_en)
  );

  // Instruction/PC register load; flush substitutes a bubble.
  always_comb begin
    inst_d  = inst_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (ld_en) begin
      pc_d = bus.pc_in;
      if (bus.flush) begin
        inst_d  = {DATA_W{1'b0}};
        valid_d = 1'b0;
      end else begin
        inst_d  = bus.inst_in;
        valid_d = 1'b1;
      end
    end else begin
      inst_d = inst_q;
    end
  end

  // Decode pipeline register.
  always_ff @(posedge clk) begin
    if (clear) begin
      inst_q  <= {DATA_W{1'b0}};
      pc_q    <= {DATA_W{1'b0}};
      valid_q <= 1'b0;
    end else begin
      inst_q  <= inst_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign rd_nb   = rd + REG_AW'(beat);
  assign imm_sum = imm + IMM_W'(beat);

  assign bus.op_code    = op;
  assign bus.rs         = rs;
  assign bus.rt         = rt;
  assign bus.rb         = bus.reg_dst ? rd_nb : rt;
  assign bus.rd_buf     = bus.call ? REG_AW'(CALL_REG) : rd_nb;
  assign bus.imm_out    = bus.imm_ext ? {{(DATA_W-IMM_W){imm_sum[IMM_W-1]}}, imm_sum}
                                      : {{(DATA_W-IMM_W){1'b0}}, imm_sum};
  assign bus.target     = pc_q + {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  assign bus.eqz        = (bus.rs_val == {DATA_W{1'b0}});
  assign bus.ltz        = bus.rs_val[DATA_W-1];
  assign bus.beat_idx   = beat;
  assign bus.last_beat  = last_beat;
  assign bus.hold_fetch = hold_fetch;
  assign bus.uop_valid  = valid_q & ~misalign;
  assign bus.illegal_op = misalign;

endmodule

// File: tb/tb_decode_seq_unit.sv
// Randomized plus directed bench for decode_seq_unit against a beat-level reference model.
module tb_decode_seq_unit;
  import decode_pkg::*;

  localparam int DATA_W = 32, REG_AW = 4, IMM_W = 14, OPC_W = 6;
  localparam int MAX_WORDS = 4, CALL_REG = 14;
  localparam int BW = $clog2(MAX_WORDS);

  logic clk = 1'b0;
  logic clear;
  always #5 clk = ~clk;

  decode_seq_unit_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .OPC_W(OPC_W), .BEAT_W(BW)) ifc ();

  decode_seq_unit #(
    .DATA_W(DATA_W), .REG_AW(REG_AW), .IMM_W(IMM_W), .OPC_W(OPC_W),
    .MAX_WORDS(MAX_WORDS), .CALL_REG(CALL_REG)
  ) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (ifc)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: current instruction, its PC, beat number, validity.
  logic [31:0] m_inst, m_pc;
  int          m_beat;
  bit          m_valid;

  function automatic int wc(input logic [31:0] ins);
    int op = int'(ins[31:26]);
    int rt = int'(ins[17:14]);
    if (op == int'(OPC_LDM) || op == int'(OPC_STM))
      return (rt + 1 > MAX_WORDS) ? MAX_WORDS : rt + 1;
    return 1;
  endfunction

  function automatic bit bad(input logic [31:0] ins);
`ifdef DECODE_RD_ALIGN_CHECK_EN
    return (wc(ins) > 1) && (int'(ins[25:22]) + wc(ins) - 1 > 15);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_edge();
    if (clear) begin
      m_inst = 32'h0; m_pc = 32'h0; m_beat = 0; m_valid = 1'b0;
    end else if (ifc.flush) begin
      m_inst = 32'h0; m_pc = ifc.pc_in; m_beat = 0; m_valid = 1'b0;
    end else if (!ifc.stall) begin
      if (!bad(m_inst) && m_beat < wc(m_inst) - 1) begin
        m_beat++;
      end else begin
        m_inst = ifc.inst_in; m_pc = ifc.pc_in; m_beat = 0; m_valid = 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    int rd = int'(m_inst[25:22]);
    int rt = int'(m_inst[17:14]);
    int imm = int'(m_inst[13:0]);
    int w = wc(m_inst);
    bit il = bad(m_inst);
    int rdb = (rd + m_beat) % 16;
    int isum = (imm + m_beat) % 16384;
    bit lst = il || (m_beat == w - 1);
    logic [31:0] eimm, etgt;
    eimm = (ifc.imm_ext && isum >= 8192) ? 32'(isum - 16384) : 32'(isum);
    etgt = m_pc + 32'((imm >= 8192) ? imm - 16384 : imm);
    check_eq("op_code", 32'(ifc.op_code), 32'(m_inst[31:26]));
    check_eq("rs", 32'(ifc.rs), 32'(m_inst[21:18]));
    check_eq("rt", 32'(ifc.rt), 32'(rt));
    check_eq("rb", 32'(ifc.rb), ifc.reg_dst ? 32'(rdb) : 32'(rt));
    check_eq("rd_buf", 32'(ifc.rd_buf), ifc.call ? 32'(CALL_REG) : 32'(rdb));
    check_eq("imm_out", ifc.imm_out, eimm);
    check_eq("target", ifc.target, etgt);
    check_eq("eqz", 32'(ifc.eqz), 32'(ifc.rs_val == 32'h0));
    check_eq("ltz", 32'(ifc.ltz), 32'(ifc.rs_val >= 32'h8000_0000));
    check_eq("beat_idx", 32'(ifc.beat_idx), 32'(m_beat));
    check_eq("last_beat", 32'(ifc.last_beat), 32'(lst));
    check_eq("hold_fetch", 32'(ifc.hold_fetch), 32'(!lst));
    check_eq("uop_valid", 32'(ifc.uop_valid), 32'(m_valid && !il));
    check_eq("illegal_op", 32'(ifc.illegal_op), 32'(il));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [3:0] rd,
                                     input logic [3:0] rs, input logic [3:0] rt,
                                     input logic [13:0] imm);
    return {op, rd, rs, rt, imm};
  endfunction

  task automatic drive_random();
    logic [31:0] r;
    logic [5:0] op;
    int sel;
    r = $urandom();
    sel = int'($urandom_range(0, 3));
    op = (sel == 0) ? OPC_LDM : (sel == 1) ? OPC_STM : 6'($urandom_range(0, 63));
    ifc.inst_in = {op, r[25:0]};
    ifc.pc_in   = $urandom();
    ifc.stall   = ($urandom_range(0, 9) < 2);
    ifc.flush   = ($urandom_range(0, 19) == 0);
    ifc.imm_ext = 1'($urandom_range(0, 1));
    ifc.call    = ($urandom_range(0, 7) == 0);
    ifc.reg_dst = 1'($urandom_range(0, 1));
    sel = int'($urandom_range(0, 7));
    ifc.rs_val  = (sel == 0) ? 32'h0 : (sel == 1) ? 32'h8000_0000 : $urandom();
    clear       = ($urandom_range(0, 59) == 0);
  endtask

  initial begin
    clear = 1'b1;
    ifc.inst_in = 32'h0; ifc.pc_in = 32'h0; ifc.stall = 1'b0; ifc.flush = 1'b0;
    ifc.imm_ext = 1'b0; ifc.call = 1'b0; ifc.reg_dst = 1'b1; ifc.rs_val = 32'h1;
    step();
    step();
    check_eq("rst_uop_valid", 32'(ifc.uop_valid), 32'd0);
    check_eq("rst_hold_fetch", 32'(ifc.hold_fetch), 32'd0);
    check_eq("rst_last_beat", 32'(ifc.last_beat), 32'd1);
    check_eq("rst_op_code", 32'(ifc.op_code), 32'd0);
    clear = 1'b0;

    // LDM rd=3 rt=2 imm=8 with a 3-cycle stall in beat 1
    ifc.inst_in = mk(OPC_LDM, 4'd3, 4'd1, 4'd2, 14'd8);
    step();
    ifc.inst_in = mk(6'h01, 4'd5, 4'd6, 4'd7, 14'd1);
    check_eq("ldm_b0_rd", 32'(ifc.rd_buf), 32'd3);
    check_eq("ldm_b0_imm", ifc.imm_out, 32'd8);
    check_eq("ldm_b0_hold", 32'(ifc.hold_fetch), 32'd1);
    step();
    check_eq("ldm_b1_rd", 32'(ifc.rd_buf), 32'd4);
    check_eq("ldm_b1_imm", ifc.imm_out, 32'd9);
    ifc.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("stall_beat", 32'(ifc.beat_idx), 32'd1);
      check_eq("stall_rd", 32'(ifc.rd_buf), 32'd4);
      check_eq("stall_imm", ifc.imm_out, 32'd9);
    end
    ifc.stall = 1'b0;
    step();
    check_eq("ldm_b2_rd", 32'(ifc.rd_buf), 32'd5);
    check_eq("ldm_b2_imm", ifc.imm_out, 32'd10);
    check_eq("ldm_b2_last", 32'(ifc.last_beat), 32'd1);
    check_eq("ldm_b2_hold", 32'(ifc.hold_fetch), 32'd0);
    step();
    check_eq("ldm_next_op", 32'(ifc.op_code), 32'h01);

    // STM rd=14 rt=7: saturates to MAX_WORDS beats
    ifc.inst_in = mk(OPC_STM, 4'd14, 4'd2, 4'd7, 14'd0);
    step();
    ifc.inst_in = mk(6'h02, 4'd1, 4'd1, 4'd1, 14'd1);
`ifdef DECODE_RD_ALIGN_CHECK_EN
    check_eq("stm_illegal", 32'(ifc.illegal_op), 32'd1);
    check_eq("stm_ill_valid", 32'(ifc.uop_valid), 32'd0);
    step();
    check_eq("stm_ill_next", 32'(ifc.op_code), 32'h02);
`else
    for (int b = 0; b < 4; b++) begin
      if (b > 0) step();
      check_eq("stm_rd_wrap", 32'(ifc.rd_buf), 32'((14 + b) % 16));
    end
    step();
    check_eq("stm_next_op", 32'(ifc.op_code), 32'h02);
`endif

    // flush in beat 1 of a 3-beat LDM
    ifc.inst_in = mk(OPC_LDM, 4'd2, 4'd0, 4'd2, 14'd4);
    step();
    step();
    ifc.flush = 1'b1;
    step();
    check_eq("flush_valid", 32'(ifc.uop_valid), 32'd0);
    check_eq("flush_beat", 32'(ifc.beat_idx), 32'd0);
    ifc.flush = 1'b0;
    ifc.inst_in = mk(6'h03, 4'd9, 4'd8, 4'd7, 14'd5);
    step();
    check_eq("flush_next_op", 32'(ifc.op_code), 32'h03);
    check_eq("flush_next_valid", 32'(ifc.uop_valid), 32'd1);

    // target and flags
    ifc.inst_in = mk(6'h04, 4'd0, 4'd0, 4'd0, 14'h3FFD);
    ifc.pc_in = 32'd10; ifc.imm_ext = 1'b0; ifc.rs_val = 32'h0;
    step();
    check_eq("tgt_target", ifc.target, 32'd7);
    check_eq("tgt_imm_zext", ifc.imm_out, 32'h0000_3FFD);
    check_eq("tgt_eqz", 32'(ifc.eqz), 32'd1);
    check_eq("tgt_ltz", 32'(ifc.ltz), 32'd0);
    ifc.rs_val = 32'h8000_0000;
    #1;
    check_eq("neg_eqz", 32'(ifc.eqz), 32'd0);
    check_eq("neg_ltz", 32'(ifc.ltz), 32'd1);

    // clear during beat 2 of a 4-beat LDM
    ifc.inst_in = mk(OPC_LDM, 4'd4, 4'd0, 4'd3, 14'd0);
    step();
    step();
    step();
    check_eq("clr_pre_beat", 32'(ifc.beat_idx), 32'd2);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check_eq("clr_beat", 32'(ifc.beat_idx), 32'd0);
    check_eq("clr_hold", 32'(ifc.hold_fetch), 32'd0);
    check_eq("clr_valid", 32'(ifc.uop_valid), 32'd0);
    check_eq("clr_op", 32'(ifc.op_code), 32'd0);

    for (int i = 0; i < 2000; i++) begin
      drive_random();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/decode_seq_unit.md
Name: decode_seq_unit

Overview:
Parametrised second-generation decode front-end for the pipelined CPU. It latches the fetched instruction and PC and extracts the opcode, register and immediate fields. It computes the branch/jump target and the zero/negative flags. It also sequences multi-word load/store instructions (LDM/STM, 1..MAX_WORDS beats) internally, replacing the externally driven add_rd/add_imm/turn_off scheme used for double-word ops. It sits between fetch and the register file/forwarding muxes; Main_Control and ALU_CU consume its op_code output.

Parameters:
DATA_W, 32, datapath and PC width
REG_AW, 4, register address width (2^REG_AW registers)
IMM_W, 14, immediate field width
OPC_W, 6, opcode width
MAX_WORDS, 4, maximum beats of one multi-word op (2..2^REG_AW)
CALL_REG, 14, link register index substituted into rd_buf on call

Ports:
clk  in  1  clock
clear  in  1  synchronous active-high reset
inst_in  in  DATA_W  instruction from fetch buffer
pc_in  in  DATA_W  PC+1 of inst_in from fetch
stall  in  1  hazard-unit freeze (hold all state)
flush  in  1  kill: load bubble instead of inst_in
imm_ext  in  1  1=sign-extend immediate, 0=zero-extend (from control)
call  in  1  current op is CALL (from control)
reg_dst  in  1  1=rb selects rd, 0=rb selects rt
rs_val  in  DATA_W  forwarded rs value for compare
op_code  out  OPC_W  opcode of current micro-op
rs, rt  out  REG_AW  source fields
rb  out  REG_AW  second read address after reg_dst mux
rd_buf  out  REG_AW  destination (rd+beat, or CALL_REG when call)
imm_out  out  DATA_W  extended immediate incl. beat offset
target  out  DATA_W  latched pc + sign-extended imm
eqz, ltz  out  1  rs_val==0, signed rs_val<0
beat_idx  out  $clog2(MAX_WORDS)  current beat number
last_beat  out  1  current micro-op is final beat
hold_fetch  out  1  fetch must hold PC/instruction
uop_valid  out  1  current micro-op is not a bubble
illegal_op  out  1  alignment fault (feature only)

Behaviour:
- Reset (clear at posedge): inst_reg<=NOP (all zero), pc_reg<=0, state IDLE, beat<=0; outputs then: op_code=0, uop_valid=0, hold_fetch=0, beat_idx=0, last_beat=1, illegal_op=0. clear beats stall and flush; clear mid-sequence aborts the sequence.
- Latency: inst_in captured at edge N; decode outputs for beat 0 are valid in cycle N+1 (one register stage). Field outputs are combinational from inst_reg and beat.
- Fields: op=[31:26], rd=[25:22], rs=[21:18], rt=[17:14], imm=[13:0], at default widths (packed MSB-first generally).
- Word count for LDM/STM: W = rt+1, saturated to MAX_WORDS. Any other opcode: W=1.
- FSM IDLE: if inst_reg is multi-word with W>1, hold_fetch=1 and last_beat=0. On a non-stalled edge go to SEQ with beat<=1; inst_reg and pc_reg hold. Else if !stall, load next instruction (or bubble if flush).
- FSM SEQ: on each non-stalled edge beat<=beat+1. When beat==W-1: last_beat=1, hold_fetch=0, and the next non-stalled edge loads the next instruction, resets beat<=0 and returns to IDLE.
- stall: all registers hold; outputs stay stable.
- flush in IDLE: inst_reg<=NOP. flush in SEQ: remaining beats abandoned, inst_reg<=NOP, state IDLE, beat<=0. flush and stall together: flush wins.
- rd_buf = CALL_REG if call, else (rd+beat) mod 2^REG_AW (wraps R15->R0). rb = rd_buf-before-call-mux if reg_dst, else rt.
- imm_out: the add (imm+beat) is computed at IMM_W bits and wraps, then it is sign/zero-extended to DATA_W per imm_ext.
- target = pc_reg + sign-extended raw imm (no beat offset), full DATA_W wrap.
- uop_valid = 0 for a bubble, 1 otherwise, including every beat.

Optional Feature:
DECODE_RD_ALIGN_CHECK_EN:
- Defined: a multi-word op with rd+W-1 > 2^REG_AW-1 raises illegal_op for one cycle (beat 0). It is decoded as a bubble: uop_valid=0, no SEQ entry, hold_fetch=0.
- Undefined: illegal_op tied 0; rd wraps as specified.

Decomposition:
- Shared package decode_pkg: opcode constants (OPC_LDM, OPC_STM, OPC_NOP=0), field position constants, state enum {IDLE, SEQ}, function word_count(rt, MAX_WORDS).
- Sub-module beat_seq: FSM plus beat counter, hold_fetch and last_beat.
- The top-level block keeps the registers, field extraction, offset adders, target adder and flags.

Test Plan:
- clear asserted during SEQ beat 2 -> next cycle beat_idx=0, hold_fetch=0, uop_valid=0, op_code=0.
- LDM rd=3, rt=2, imm=8 -> beats 0..2 give rd_buf=3,4,5 and imm_out=8,9,10; hold_fetch=1,1,0; last_beat on beat 2; next instruction decoded in the following cycle.
- STM rt=7 with MAX_WORDS=4 -> exactly 4 beats. rd=14 wraps to rd_buf=14,15,0,1 (feature off); with feature on -> illegal_op=1 for one cycle and uop_valid=0.
- stall held 3 cycles in beat 1 -> beat_idx, rd_buf and imm_out constant; on release, beat 2 follows.
- flush during beat 1 of a 3-beat LDM -> next cycle IDLE, uop_valid=0; the instruction after that decodes normally.
- pc_in=10, imm=-3 (14'h3FFD), imm_ext=0 -> target=7 and imm_out=32'h00003FFD. rs_val=0 gives eqz=1, ltz=0; rs_val=32'h80000000 gives eqz=0, ltz=1.
